mux_scan_ctrl: RTL and testbench

//  Address sequencer that sits directly upstream of the 7:1 bit mux (mux7to1).
//  - Drives the mux addr port through channels 0..6, holding each one for DWELL cycles.
//  - Captures the mux output for each channel and presents all 7 bits as one sample word.
//  - Offers single-shot or continuous scanning, controlled by start/abort/busy/valid.

---
 rtl/mux_scan_ctrl.sv | 104 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Address sequencer for a 7:1 bit mux: steps addr 0..6, dwelling DWELL
// cycles per channel, and assembles the captured bits into a sample word.
module mux_scan_ctrl #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       abort,
   input  logic       mux_out,
   output logic [2:0] addr,
   output logic [6:0] sample,
   output logic       valid,
   output logic       busy
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);
   localparam logic [2:0]       LAST   = 3'd6;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [5:0]       acc, acc_nx;
   logic [2:0]       addr_nx;
   logic [6:0]       sample_nx;
   logic             valid_nx;
   logic             busy_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         addr   <= '0;
         sample <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         acc    <= acc_nx;
         addr   <= addr_nx;
         sample <= sample_nx;
         valid  <= valid_nx;
         busy   <= busy_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      acc_nx    = acc;
      addr_nx   = addr;
      sample_nx = sample;
      valid_nx  = 1'b0;
      busy_nx   = busy;
      if (abort) begin
         // Partial scan is thrown away; sample keeps the last full word
         state_nx = IDLE;
         cnt_nx   = '0;
         acc_nx   = '0;
         addr_nx  = '0;
         busy_nx  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_nx = SCAN;
                  cnt_nx   = RELOAD;
                  acc_nx   = '0;
                  addr_nx  = '0;
                  busy_nx  = 1'b1;
               end
            end
            SCAN: begin
               if (cnt != '0) begin
                  cnt_nx = cnt - 1'b1;
               end else if (addr != LAST) begin
                  for (int i = 0; i < 6; i++)
                     if (addr == 3'(i)) acc_nx[i] = mux_out;
                  addr_nx = addr + 3'd1;
                  cnt_nx  = RELOAD;
               end else begin
                  sample_nx = {mux_out, acc};
                  valid_nx  = 1'b1;
                  addr_nx   = '0;
                  acc_nx    = '0;
                  cnt_nx    = RELOAD;
                  if (!cont) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                     busy_nx  = 1'b0;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with DWELL=2 and a behavioural
// 7:1 mux; the monitor pops expected samples whenever valid pulses.
module tb_mux_scan_ctrl;

   localparam int D = 2;

   logic       clk = 1'b0;
   logic       rst, start, cont, abort, mux_out;
   logic [2:0] addr;
   logic [6:0] sample;
   logic       valid, busy;
   logic [6:0] ch;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   int e;

   typedef struct {
      logic [6:0] s;
      int         t;
   } exp_t;

   exp_t q[$];

   assign mux_out = ch[addr];

   mux_scan_ctrl #(.DWELL(D), .CNT_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cont   (cont),
      .abort  (abort),
      .mux_out(mux_out),
      .addr   (addr),
      .sample (sample),
      .valid  (valid),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h want %0h (edge %0d)", n, act, req, cyc);
      end
   endtask

   // Monitor: cyc is the number of rising edges seen so far
   always @(posedge clk) begin
      exp_t x;
      #1;
      cyc++;
      if (!rst) chk("addr_range", {31'd0, addr <= 3'd6}, 32'd1);
      if (valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            x = q.pop_front();
            chk("sample", {25'd0, sample}, {25'd0, x.s});
            chk("valid_time", cyc, x.t);
         end
      end
   end

   task automatic wait_until(int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic pulse_start(output int edge_e);
      @(negedge clk);
      start  = 1'b1;
      edge_e = cyc + 1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      cont  = 1'b0;
      abort = 1'b0;
      ch    = 7'd0;

      // 1. reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_addr", {29'd0, addr}, 32'd0);
      chk("rst_sample", {25'd0, sample}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // 2. single scan
      ch = 7'b0101010;
      pulse_start(e);
      q.push_back('{s: 7'b0101010, t: e + 7*D});
      for (int k = 0; k < 7; k++) begin
         wait_until(e + D*k + 1);
         chk("s2_addr", {29'd0, addr}, k);
      end
      wait_until(e + 7*D - 1);
      chk("s2_busy_hi", {31'd0, busy}, 32'd1);
      wait_until(e + 7*D);
      chk("s2_busy_lo", {31'd0, busy}, 32'd0);
      chk("s2_addr_end", {29'd0, addr}, 32'd0);

      // 3. continuous
      ch   = 7'b1010101;
      cont = 1'b1;
      pulse_start(e);
      q.push_back('{s: 7'b1010101, t: e + 14});
      q.push_back('{s: 7'b1010101, t: e + 28});
      q.push_back('{s: 7'b1010101, t: e + 42});
      wait_until(e + 28);
      chk("s3_busy_mid", {31'd0, busy}, 32'd1);
      wait_until(e + 29);
      cont = 1'b0;
      wait_until(e + 41);
      chk("s3_busy_hi", {31'd0, busy}, 32'd1);
      wait_until(e + 42);
      chk("s3_busy_lo", {31'd0, busy}, 32'd0);

      // 4. abort at addr 3
      ch = 7'b1111111;
      pulse_start(e);
      wait_until(e + 7);
      chk("s4_addr3", {29'd0, addr}, 32'd3);
      abort = 1'b1;
      wait_until(e + 8);
      abort = 1'b0;
      chk("s4_addr", {29'd0, addr}, 32'd0);
      chk("s4_busy", {31'd0, busy}, 32'd0);
      chk("s4_valid", {31'd0, valid}, 32'd0);
      chk("s4_sample", {25'd0, sample}, 32'b1010101);
      wait_until(e + 20);
      chk("s4_idle", {31'd0, busy}, 32'd0);

      // 5. ignored starts, then abort+start in IDLE
      ch = 7'b0101010;
      pulse_start(e);
      q.push_back('{s: 7'b0101010, t: e + 14});
      wait_until(e + 2);
      start = 1'b1;
      wait_until(e + 3);
      start = 1'b0;
      wait_until(e + 9);
      start = 1'b1;
      wait_until(e + 10);
      start = 1'b0;
      wait_until(e + 11);
      chk("s5_addr5", {29'd0, addr}, 32'd5);
      wait_until(e + 14);
      chk("s5_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("s5_abort_start", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge clk);
      chk("s5_still_idle", {31'd0, busy}, 32'd0);

      // 6. g changes before the channel-6 capture
      ch = 7'b0000000;
      pulse_start(e);
      q.push_back('{s: 7'b1000000, t: e + 14});
      wait_until(e + 12);
      ch[6] = 1'b1;
      wait_until(e + 14);
      chk("s6_sample", {25'd0, sample}, 32'b1000000);

      // reset mid-scan clears sample
      pulse_start(e);
      wait_until(e + 4);
      rst = 1'b1;
      wait_until(e + 5);
      rst = 1'b0;
      chk("rst_mid_sample", {25'd0, sample}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_addr", {29'd0, addr}, 32'd0);
      repeat (20) @(negedge clk);

      chk("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
